// File: rtl/add6_pkg.sv
// Shared constants and state encoding for the 6-bit shift-add multiply sequencer.
package add6_pkg;
  localparam int W     = 6;
  localparam int CNT_W = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/add6_mul_seq.sv
// Shift-add multiplier that borrows an external W-bit ripple adder, one add per cycle.
// The multiplier register doubles as the low product half as it shifts out.
module add6_mul_seq
  import add6_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product,
  output logic [W-1:0]   add_a,
  output logic [W-1:0]   add_b,
  output logic           add_cin,
  input  logic [W-1:0]   add_sum,
  input  logic           add_cout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     mcand_q, mcand_d;
  logic [W-1:0]     mplr_q,  mplr_d;
  logic [W-1:0]     acc_q,   acc_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [2*W-1:0]   product_q, product_d;
  logic [2*W-1:0]   shifted;

  // Carry-out lands in the top bit, so the accumulator never overflows.
  assign shifted = {add_cout, add_sum, mplr_q[W-1:1]};

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    add_a     = '0;
    add_b     = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a;
          mplr_d  = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        add_a           = acc_q;
        add_b           = mplr_q[0] ? mcand_q : '0;
        {acc_d, mplr_d} = shifted;
        cnt_d           = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          product_d = shifted;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplr_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == RUN) || (state_q == DONE);
  assign done    = (state_q == DONE);
  assign product = product_q;
  assign add_cin = 1'b0;

endmodule

// File: tb/tb_add6_mul_seq.sv
// Closed-loop bench: a behavioural 6-bit adder sits on add_*, directed vectors plus full a/b sweep.
module tb_add6_mul_seq;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [5:0]  a, b;
  logic        busy, done;
  logic [11:0] product;
  logic [5:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;

  int n_chk  = 0;
  int n_pass = 0;
  int done_run = 0;
  int done_max = 0;

  add6_mul_seq dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  assign {add_cout, add_sum} = 7'(add_a) + 7'(add_b) + 7'(add_cin);

  always #5 clk = ~clk;

  // Track longest run of consecutive done cycles.
  always @(negedge clk) begin
    if (done) done_run = done_run + 1;
    else      done_run = 0;
    if (done_run > done_max) done_max = done_run;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Drives one multiply from IDLE; counts edges (including the sampling edge) until done.
  task automatic do_mul(input string tag, input logic [5:0] ta, input logic [5:0] tb_v,
                        input logic [11:0] exp, input bit full);
    int lat;
    a = ta; b = tb_v; start = 1'b1;
    @(posedge clk); #1 start = 1'b0; lat = 1;
    while (!done && lat < 20) begin
      @(posedge clk); #1 lat++;
    end
    if (full) chk({tag, "_lat"}, lat, 7);
    chk({tag, "_prod"}, product, exp);
    @(posedge clk); #1;
    if (full) chk({tag, "_busy_drop"}, busy, 0);
  endtask

  initial begin
    int lat, n_done, done_lat, gap;
    logic [11:0] p_at_done;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_prod", product, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_cin", add_cin, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_mul("m42x5", 6'd42, 6'd5, 12'd210, 1);
    do_mul("m63x63", 6'd63, 6'd63, 12'hF81, 1);
    do_mul("m63x1", 6'd63, 6'd1, 12'd63, 1);
    do_mul("m1x63", 6'd1, 6'd63, 12'd63, 1);
    do_mul("m0x63", 6'd0, 6'd63, 12'd0, 1);
    do_mul("m37x0", 6'd37, 6'd0, 12'd0, 1);

    // Start pulse mid-RUN must be ignored; inputs changing mid-RUN have no effect.
    a = 6'd7; b = 6'd9; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 1; n_done = 0; done_lat = 0; p_at_done = '0;
    repeat (20) begin
      @(posedge clk); #1 lat++;
      if (lat == 3) begin a = 6'd1; b = 6'd1; start = 1'b1; end
      if (lat == 4) start = 1'b0;
      if (done) begin n_done++; done_lat = lat; p_at_done = product; end
    end
    chk("ign_ndone", n_done, 1);
    chk("ign_lat", done_lat, 7);
    chk("ign_prod", p_at_done, 63);

    // Start held high: back-to-back results every W+2 cycles.
    a = 6'd3; b = 6'd5; start = 1'b1;
    lat = 0;
    do begin @(posedge clk); #1 lat++; end while (!done && lat < 30);
    chk("held_first", done, 1);
    chk("held_prod1", product, 15);
    gap = 0;
    do begin @(posedge clk); #1 gap++; end while (!done && gap < 30);
    chk("held_gap", gap, 8);
    chk("held_prod2", product, 15);
    start = 1'b0;
    @(posedge clk); #1;

    // Reset during RUN at cnt=3 aborts without a done pulse.
    a = 6'd13; b = 6'd11; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("rmid_busy", busy, 0);
    chk("rmid_prod", product, 0);
    n_done = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    chk("rmid_ndone", n_done, 0);
    do_mul("m10x10", 6'd10, 6'd10, 12'd100, 1);

    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 64; j++)
        do_mul("sweep", 6'(i), 6'(j), 12'(i * j), 0);

    chk("done_pulse_max", done_max, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
